// File: rtl/time_set_ctrl.sv
// Set-time edit sequencer: captures the running time, steps hours/minutes/seconds, loads the counter on exit.
// Optional feature macro: AUTO_REPEAT_EN (held add/sub auto-repeat); default build is edge-only stepping.
module time_set_ctrl #(
    parameter int BLINK_DIV    = 50000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       set_en,
    input  logic       next_field,
    input  logic       add,
    input  logic       sub,
    input  logic       cancel,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    input  logic [7:0] cur_seconds,
    output logic [7:0] new_hours,
    output logic [7:0] new_minutes,
    output logic [7:0] new_seconds,
    output logic       load,
    output logic [1:0] field,
    output logic       blink
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_H,
        ST_EDIT_M,
        ST_EDIT_S,
        ST_COMMIT
    } state_t;

    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    state_t r_state;
    state_t w_state_next;

    logic r_next_d, r_add_d, r_sub_d, r_cancel_d;
    logic w_next_edge, w_add_edge, w_sub_edge, w_cancel_edge;
    logic w_editing, w_editing_next;
    logic w_field_chg, w_do_inc, w_do_dec;
    logic w_rep_inc, w_rep_dec;

    logic [7:0] r_new_hours, r_new_minutes, r_new_seconds;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic r_blink;

    function automatic logic [7:0] f_inc(input logic [7:0] v, input logic [7:0] vmax);
        return (v >= vmax) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] f_dec(input logic [7:0] v, input logic [7:0] vmax);
        return ((v == 8'd0) || (v > vmax)) ? vmax : v - 8'd1;
    endfunction

    assign w_next_edge   = next_field & ~r_next_d;
    assign w_add_edge    = add & ~r_add_d;
    assign w_sub_edge    = sub & ~r_sub_d;
    assign w_cancel_edge = cancel & ~r_cancel_d;

    assign w_editing      = (r_state == ST_EDIT_H) || (r_state == ST_EDIT_M) || (r_state == ST_EDIT_S);
    assign w_editing_next = (w_state_next == ST_EDIT_H) || (w_state_next == ST_EDIT_M) ||
                            (w_state_next == ST_EDIT_S);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_next_d   <= 1'b0;
            r_add_d    <= 1'b0;
            r_sub_d    <= 1'b0;
            r_cancel_d <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_next_d   <= next_field;
            r_add_d    <= add;
            r_sub_d    <= sub;
            r_cancel_d <= cancel;
        end
    end

    // Exit priority inside an edit state: cancel, then set_en fall, then field advance, then stepping.
    always_comb begin
        w_state_next = r_state;
        w_field_chg  = 1'b0;
        w_do_inc     = 1'b0;
        w_do_dec     = 1'b0;
        load         = 1'b0;
        field        = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (set_en) w_state_next = ST_EDIT_H;
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                case (r_state)
                    ST_EDIT_H: field = 2'b01;
                    ST_EDIT_M: field = 2'b10;
                    default:   field = 2'b11;
                endcase
                if (w_cancel_edge) begin
                    w_state_next = ST_IDLE;
                end else if (!set_en) begin
                    w_state_next = ST_COMMIT;
                end else if (w_next_edge) begin
                    w_field_chg = 1'b1;
                    case (r_state)
                        ST_EDIT_H: w_state_next = ST_EDIT_M;
                        ST_EDIT_M: w_state_next = ST_EDIT_S;
                        default:   w_state_next = ST_EDIT_H;
                    endcase
                end else begin
                    w_do_inc = (w_add_edge & ~w_sub_edge) | w_rep_inc;
                    w_do_dec = (w_sub_edge & ~w_add_edge) | w_rep_dec;
                end
            end
            ST_COMMIT: begin
                load         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic r_rep_live;
    logic w_held_alone, w_rep_fire;

    // Counter is armed only by a fresh edge; zero means idle, so a level left over from a chord never repeats.
    assign w_held_alone = w_editing & (add ^ sub);
    assign w_rep_fire   = w_held_alone & ~w_add_edge & ~w_sub_edge & (r_rep_cnt != '0) &
                          (r_rep_live ? (r_rep_cnt == REP_W'(REPEAT_RATE))
                                      : (r_rep_cnt == REP_W'(REPEAT_DELAY)));
    assign w_rep_inc    = w_rep_fire & add;
    assign w_rep_dec    = w_rep_fire & sub;

    always_ff @(posedge CLK100MHZ) begin
        if (reset || !w_held_alone || w_field_chg || !w_editing_next) begin
            r_rep_cnt  <= '0;
            r_rep_live <= 1'b0;
        end else if (w_add_edge || w_sub_edge) begin
            r_rep_cnt  <= REP_W'(1);
            r_rep_live <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt  <= REP_W'(1);
            r_rep_live <= 1'b1;
        end else if (r_rep_cnt != '0) begin
            r_rep_cnt  <= r_rep_cnt + REP_W'(1);
        end
    end
`else
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_DELAY != REPEAT_RATE);
    assign w_rep_inc       = 1'b0;
    assign w_rep_dec       = 1'b0;
`endif

    // IDLE shadows the running time, so the capture on set_en is the same path as tracking.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_new_hours   <= 8'd0;
            r_new_minutes <= 8'd0;
            r_new_seconds <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            r_new_hours   <= cur_hours;
            r_new_minutes <= cur_minutes;
            r_new_seconds <= cur_seconds;
        end else if (w_do_inc || w_do_dec) begin
            case (r_state)
                ST_EDIT_H: r_new_hours   <= w_do_inc ? f_inc(r_new_hours, 8'd23)
                                                     : f_dec(r_new_hours, 8'd23);
                ST_EDIT_M: r_new_minutes <= w_do_inc ? f_inc(r_new_minutes, 8'd59)
                                                     : f_dec(r_new_minutes, 8'd59);
                ST_EDIT_S: r_new_seconds <= w_do_inc ? f_inc(r_new_seconds, 8'd59)
                                                     : f_dec(r_new_seconds, 8'd59);
                default: ;
            endcase
        end
    end

    // Blink phase restarts lit on edit entry and on every field change.
    always_ff @(posedge CLK100MHZ) begin
        if (reset || !w_editing_next) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (!w_editing || w_field_chg) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    assign new_hours   = r_new_hours;
    assign new_minutes = r_new_minutes;
    assign new_seconds = r_new_seconds;
    assign blink       = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_time_set_ctrl;

    localparam int BLINK_DIV    = 4;
    localparam int REPEAT_DELAY = 8;
    localparam int REPEAT_RATE  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       setEn = 1'b0, nextField = 1'b0, addBtn = 1'b0, subBtn = 1'b0, cancelBtn = 1'b0;
    logic [7:0] curH = 8'd0, curM = 8'd0, curS = 8'd0;
    logic [7:0] newH, newM, newS;
    logic       load, blink;
    logic [1:0] field;

    int nChecks = 0;
    int nPass = 0;
    int loadSeen = 0;

    time_set_ctrl #(
        .BLINK_DIV(BLINK_DIV), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) dut (
        .CLK100MHZ(clk), .reset(reset), .set_en(setEn), .next_field(nextField),
        .add(addBtn), .sub(subBtn), .cancel(cancelBtn),
        .cur_hours(curH), .cur_minutes(curM), .cur_seconds(curS),
        .new_hours(newH), .new_minutes(newM), .new_seconds(newS),
        .load(load), .field(field), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load === 1'b1) loadSeen++;

    // Behavioural model: the edit session as a time triple, a field index and an age since the blink restarted.
    int  mT[3];
    int  mMax[3] = '{23, 59, 59};
    bit  mEdit, mLoad;
    int  mFld, mAge, mRep;
    bit  pNext, pAdd, pSub, pCancel;
    bit  eNext, eAdd, eSub, eCancel;

    always @(posedge clk) begin
        if (reset) begin
            mT = '{0, 0, 0}; mEdit = 0; mLoad = 0; mFld = 1; mAge = 0; mRep = -1;
            pNext = 0; pAdd = 0; pSub = 0; pCancel = 0;
        end else begin
            eNext = nextField & !pNext; eAdd = addBtn & !pAdd;
            eSub = subBtn & !pSub; eCancel = cancelBtn & !pCancel;
            pNext = nextField; pAdd = addBtn; pSub = subBtn; pCancel = cancelBtn;
            if (mLoad) begin
                mLoad = 0;
            end else if (!mEdit) begin
                mT = '{int'(curH), int'(curM), int'(curS)};
                if (setEn) begin mEdit = 1; mFld = 1; mAge = 0; mRep = -1; end
            end else if (eCancel) begin
                mEdit = 0;
            end else if (!setEn) begin
                mEdit = 0; mLoad = 1;
            end else if (eNext) begin
                mFld = (mFld % 3) + 1; mAge = 0; mRep = -1;
            end else begin
                mAge++;
                if (eAdd && !eSub) mT[mFld-1] = (mT[mFld-1] + 1) % (mMax[mFld-1] + 1);
                if (eSub && !eAdd) mT[mFld-1] = (mT[mFld-1] + mMax[mFld-1]) % (mMax[mFld-1] + 1);
`ifdef AUTO_REPEAT_EN
                if (addBtn != subBtn) begin
                    if (eAdd || eSub) mRep = 0;
                    else if (mRep >= 0) begin
                        mRep++;
                        if (mRep >= REPEAT_DELAY && (mRep - REPEAT_DELAY) % REPEAT_RATE == 0) begin
                            if (addBtn) mT[mFld-1] = (mT[mFld-1] + 1) % (mMax[mFld-1] + 1);
                            else mT[mFld-1] = (mT[mFld-1] + mMax[mFld-1]) % (mMax[mFld-1] + 1);
                        end
                    end
                end else mRep = -1;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        nChecks++;
        if ({newH, newM, newS, load, field, blink} !== 28'd0)
            $display("[TB] FAIL reset_outputs: got %h:%h:%h load=%b field=%b blink=%b, want all zero",
                     newH, newM, newS, load, field, blink);
        else nPass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_capture_commit();
        int ls;
        curH = 8'd13; curM = 8'd45; curS = 8'd30;
        tick();
        setEn = 1'b1;
        tick();
        nChecks++;
        if (field !== 2'b01 || blink !== 1'b1 || {newH, newM, newS} !== {8'd13, 8'd45, 8'd30})
            $display("[TB] FAIL capture: got field=%b blink=%b %0d:%0d:%0d, want 01 1 13:45:30",
                     field, blink, newH, newM, newS);
        else nPass++;
        curH = 8'd1; curM = 8'd2; curS = 8'd3;
        repeat (3) tick();
        nChecks++;
        if (blink !== 1'b1) $display("[TB] FAIL blink_hold: got %b want 1", blink); else nPass++;
        tick();
        nChecks++;
        if (blink !== 1'b0) $display("[TB] FAIL blink_toggle: got %b want 0", blink); else nPass++;
        ls = loadSeen;
        setEn = 1'b0;
        tick();
        nChecks++;
        if (load !== 1'b1 || field !== 2'b00 || blink !== 1'b0 || {newH, newM, newS} !== {8'd13, 8'd45, 8'd30})
            $display("[TB] FAIL commit: got load=%b field=%b blink=%b %0d:%0d:%0d, want 1 00 0 13:45:30",
                     load, field, blink, newH, newM, newS);
        else nPass++;
        tick();
        nChecks++;
        if (load !== 1'b0 || {newH, newM, newS} !== {8'd13, 8'd45, 8'd30})
            $display("[TB] FAIL post_commit: got load=%b %0d:%0d:%0d, want 0 13:45:30", load, newH, newM, newS);
        else nPass++;
        tick();
        nChecks++;
        if ({newH, newM, newS} !== {8'd1, 8'd2, 8'd3} || loadSeen - ls != 1)
            $display("[TB] FAIL track_after_commit: got %0d:%0d:%0d loads=%0d, want 1:2:3 loads=1",
                     newH, newM, newS, loadSeen - ls);
        else nPass++;
    endtask

    task automatic test_hours_wrap();
        logic [7:0] want[4] = '{8'd0, 8'd23, 8'd0, 8'd23};
        curH = 8'd23; curM = 8'd0; curS = 8'd0;
        setEn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) addBtn = 1'b1; else subBtn = 1'b1;
            tick();
            nChecks++;
            if (newH !== want[i]) $display("[TB] FAIL hours_wrap_%0d: got %0d want %0d", i, newH, want[i]);
            else nPass++;
            addBtn = 1'b0; subBtn = 1'b0;
            tick();
        end
        curH = 8'd5;
        setEn = 1'b0;
        tick();
        nChecks++;
        if (load !== 1'b1 || newH !== 8'd23) $display("[TB] FAIL hours_commit: got load=%b h=%0d want 1 23", load, newH);
        else nPass++;
        tick();
    endtask

    task automatic test_min_sec_fields();
        logic [7:0] want[3] = '{8'd59, 8'd0, 8'd1};
        curH = 8'd10; curM = 8'd58; curS = 8'd7;
        setEn = 1'b1;
        tick();
        nextField = 1'b1; tick(); nextField = 1'b0;
        nChecks++;
        if (field !== 2'b10 || blink !== 1'b1) $display("[TB] FAIL field_min: got %b blink=%b want 10 1", field, blink);
        else nPass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            addBtn = 1'b1; tick();
            nChecks++;
            if (newM !== want[i] || newH !== 8'd10 || newS !== 8'd7)
                $display("[TB] FAIL minutes_add_%0d: got %0d:%0d:%0d want 10:%0d:7", i, newH, newM, newS, want[i]);
            else nPass++;
            addBtn = 1'b0; tick();
        end
        nextField = 1'b1; tick(); nextField = 1'b0; tick();
        nChecks++;
        if (field !== 2'b11) $display("[TB] FAIL field_sec: got %b want 11", field); else nPass++;
        nextField = 1'b1; tick(); nextField = 1'b0; tick();
        nChecks++;
        if (field !== 2'b01) $display("[TB] FAIL field_wrap: got %b want 01", field); else nPass++;
        setEn = 1'b0; tick();
        // set_en re-asserted during the commit cycle must re-enter hours editing after IDLE.
        setEn = 1'b1; tick();
        nChecks++;
        if (field !== 2'b00 || load !== 1'b0) $display("[TB] FAIL reenter_idle: got field=%b load=%b want 00 0", field, load);
        else nPass++;
        tick();
        nChecks++;
        if (field !== 2'b01) $display("[TB] FAIL reenter_edit: got %b want 01", field); else nPass++;
        setEn = 1'b0; tick(); tick();
    endtask

    task automatic test_cancel();
        int ls;
        curH = 8'd10; curM = 8'd20; curS = 8'd30;
        tick();
        ls = loadSeen;
        setEn = 1'b1; tick();
        repeat (2) begin addBtn = 1'b1; tick(); addBtn = 1'b0; tick(); end
        nChecks++;
        if (newH !== 8'd12) $display("[TB] FAIL cancel_pre: got %0d want 12", newH); else nPass++;
        cancelBtn = 1'b1; tick(); cancelBtn = 1'b0;
        nChecks++;
        if (field !== 2'b00 || load !== 1'b0) $display("[TB] FAIL cancel_exit: got field=%b load=%b want 00 0", field, load);
        else nPass++;
        setEn = 1'b0; curH = 8'd4; tick(); tick();
        nChecks++;
        if ({newH, newM, newS} !== {8'd4, 8'd20, 8'd30} || loadSeen != ls)
            $display("[TB] FAIL cancel_track: got %0d:%0d:%0d loads=%0d, want 4:20:30 loads=0",
                     newH, newM, newS, loadSeen - ls);
        else nPass++;
    endtask

    task automatic test_simultaneous();
        int ls;
        curH = 8'd6; curM = 8'd7; curS = 8'd8;
        setEn = 1'b1; tick();
        addBtn = 1'b1; subBtn = 1'b1; tick(); addBtn = 1'b0; subBtn = 1'b0;
        nChecks++;
        if (newH !== 8'd6) $display("[TB] FAIL add_sub_same: got %0d want 6", newH); else nPass++;
        tick();
        ls = loadSeen;
        cancelBtn = 1'b1; setEn = 1'b0; tick(); cancelBtn = 1'b0; tick();
        nChecks++;
        if (loadSeen != ls || field !== 2'b00)
            $display("[TB] FAIL cancel_and_fall: got loads=%0d field=%b want 0 00", loadSeen - ls, field);
        else nPass++;
        setEn = 1'b1; tick();
        nextField = 1'b1; tick(); nextField = 1'b0;
        reset = 1'b1; tick();
        nChecks++;
        if ({newH, newM, newS, load, field, blink} !== 28'd0)
            $display("[TB] FAIL reset_mid_edit: got %0d:%0d:%0d load=%b field=%b blink=%b want zeros",
                     newH, newM, newS, load, field, blink);
        else nPass++;
        reset = 1'b0; setEn = 1'b0; tick();
    endtask

    task automatic test_auto_repeat();
        int want;
`ifdef AUTO_REPEAT_EN
        want = 5;
`else
        want = 1;
`endif
        curH = 8'd0; curM = 8'd0; curS = 8'd0;
        setEn = 1'b1; tick();
        repeat (2) begin nextField = 1'b1; tick(); nextField = 1'b0; tick(); end
        addBtn = 1'b1;
        repeat (15) tick();
        addBtn = 1'b0; tick();
        nChecks++;
        if (newS !== 8'(want)) $display("[TB] FAIL auto_repeat: got %0d want %0d", newS, want); else nPass++;
        setEn = 1'b0; tick(); tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) setEn = ~setEn;
            nextField = ($urandom_range(0, 5) == 0);
            addBtn = ($urandom_range(0, 2) == 0);
            subBtn = ($urandom_range(0, 3) == 0);
            cancelBtn = ($urandom_range(0, 39) == 0);
            curH = 8'($urandom_range(0, 23)); curM = 8'($urandom_range(0, 59)); curS = 8'($urandom_range(0, 59));
            tick();
            nChecks++;
            if ({newH, newM, newS} !== {8'(mT[0]), 8'(mT[1]), 8'(mT[2])} || load !== mLoad ||
                field !== (mEdit ? 2'(mFld) : 2'b00) ||
                blink !== (mEdit && ((mAge / BLINK_DIV) % 2 == 0))) begin
                if (bad < 10)
                    $display("[TB] FAIL random_%0d: got %0d:%0d:%0d load=%b field=%b blink=%b, want %0d:%0d:%0d load=%b field=%0d blink=%b",
                             i, newH, newM, newS, load, field, blink, mT[0], mT[1], mT[2], mLoad,
                             mEdit ? mFld : 0, mEdit && ((mAge / BLINK_DIV) % 2 == 0));
                bad++;
            end else nPass++;
        end
        reset = 1'b0; setEn = 1'b0; nextField = 1'b0; addBtn = 1'b0; subBtn = 1'b0; cancelBtn = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_capture_commit();
        test_hours_wrap();
        test_min_sec_fields();
        test_cancel();
        test_simultaneous();
        test_auto_repeat();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
